debug_ctrl: RTL
===============

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 The module SHALL have exactly one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Port clk  in  1  rising-edge clock shared with the PC unit.
REQ-003 Port rst  in  1  synchronous active-high reset.
REQ-004 Port PC  in  32  current fetch address driven by the PC unit.
REQ-005 Port Stall  in  1  pipeline stall; when 1 the PC does not advance this cycle.
REQ-006 Port BpSet  in  1  loads BpAddr into the breakpoint register.
REQ-007 Port BpAddr  in  32  breakpoint address.
REQ-008 Port BpEn  in  1  breakpoint compare enable.
REQ-009 Port HaltReq  in  1  manual pause pulse.
REQ-010 Port Run  in  1  resume pulse.
REQ-011 Port Step  in  1  single-step pulse.
REQ-012 Port Break  out  1  requests PC forced to 32'hffffffff.
REQ-013 Port Continue  out  1  one-cycle request to restore the PC from history.
REQ-014 Port Halted  out  1  status; high in state HALTED.
REQ-015 Port BreakPC  out  32  PC captured at the halt event.
REQ-016 Port InstrCount  out  32  count of advancing fetch cycles.
REQ-017 Port HitCount  out  8  count of breakpoint hits.

Function
REQ-018 The FSM SHALL have states RUN, HALTED, CONT and STEP; all outputs SHALL be registered.
REQ-019 In RUN, a halt event (BpEn=1 & PC==BpReg & Stall=0 & Skip=0, or HaltReq=1) SHALL move to HALTED next cycle, capture BreakPC<=PC, and set Break=1.
REQ-020 A breakpoint-caused halt SHALL increment HitCount, saturating at 255; a HaltReq-only halt SHALL NOT increment HitCount.
REQ-021 In HALTED, Break=1 and Halted=1 every cycle; Run or Step SHALL move to CONT with Break=0 and Continue=1 for exactly one cycle.
REQ-022 Run and Step asserted in the same HALTED cycle: Run wins.
REQ-023 From CONT, a Run-initiated resume SHALL go to RUN; a Step-initiated resume SHALL go to STEP, with the initiator recorded in a flag.
REQ-024 In STEP, the first cycle with Stall=0 SHALL return to HALTED, capture BreakPC<=PC and set Break=1; with Stall=1 the FSM SHALL remain in STEP.
REQ-025 Entering RUN from CONT SHALL set Skip=1; Skip SHALL clear on the first cycle with PC!=BreakPC, so a resume never re-hits the same breakpoint immediately.
REQ-026 Run, Step and HaltReq SHALL be ignored outside the states in which they are defined.
REQ-027 BpSet SHALL load BpReg at the clock edge; a compare in the same cycle SHALL use the old BpReg.
REQ-028 InstrCount SHALL increment by 1 on every RUN or STEP cycle with Stall=0 and Break=0, and SHALL wrap from 32'hffffffff to 0.
REQ-029 Continue and Break SHALL never be 1 in the same cycle.

Reset
REQ-030 On rst=1 at a clock edge: state=RUN, Break=0, Continue=0, Halted=0, BreakPC=0, InstrCount=0, HitCount=0, BpReg=0, Skip=0.
REQ-031 Reset asserted in any state, including mid-HALTED or mid-STEP, SHALL take effect on the next edge and override all other inputs.

Verification
REQ-032 BpSet with 32'h0000_0010, BpEn=1, PC stepping by 4 from 0 -> Break=1 and Halted=1 one cycle after PC==32'h10, BreakPC=32'h10, HitCount=1.
REQ-033 In HALTED, pulse Run -> Continue=1 for one cycle with Break=0, then RUN; PC stays 32'h10 for two cycles -> no re-halt, and Skip clears when PC becomes 32'h14.
REQ-034 In HALTED, pulse Step with Stall=1 for 3 cycles -> FSM stays in STEP; on the first Stall=0 cycle -> HALTED with BreakPC equal to the PC of that cycle.
REQ-035 Run and Step pulsed together in HALTED -> Run path taken and Halted=0 after CONT; 256 breakpoint hits -> HitCount=255.
REQ-036 Preload InstrCount=32'hffffffff, then one advancing cycle -> InstrCount=0; rst asserted while HALTED -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/debug_ctrl.sv
// Debug controller: breakpoint compare, halt/resume/single-step sequencing,
// and instruction / breakpoint-hit counters for the fetch unit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_RUN    | normal execution, watching for breakpoint or manual halt
// S_HALTED | PC held at the break vector, waiting for Run or Step
// S_CONT   | one-cycle resume, PC restored from history (Continue=1)
// S_STEP   | executing a single instruction, halts on first unstalled cycle
module debug_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        BpSet,
  input  logic [31:0] BpAddr,
  input  logic        BpEn,
  input  logic        HaltReq,
  input  logic        Run,
  input  logic        Step,
  output logic        Break,
  output logic        Continue,
  output logic        Halted,
  output logic [31:0] BreakPC,
  output logic [31:0] InstrCount,
  output logic [7:0]  HitCount
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_CONT   = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] bp_reg;
  logic [31:0] instr_cnt;
  logic        skip, skip_nxt;
  logic        step_mode, step_mode_nxt;
  logic        capture_pc, hit_inc;
  logic        bp_hit, halt_evt, advance;

  // Skip masks the breakpoint right after a resume so the PC that caused the
  // halt does not immediately trap again.
  assign bp_hit   = BpEn && (PC == bp_reg) && !Stall && !skip;
  assign halt_evt = bp_hit || HaltReq;
  assign advance  = ((state == S_RUN) || (state == S_STEP)) && !Stall && !Break;

  assign InstrCount = instr_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next-state decode plus the side-effect strobes that go with each transition.
  always_comb begin
    state_nxt     = state;
    step_mode_nxt = step_mode;
    capture_pc    = 1'b0;
    hit_inc       = 1'b0;
    skip_nxt      = skip && (PC == BreakPC);
    case (state)
      S_RUN: begin
        if (halt_evt) begin
          state_nxt  = S_HALTED;
          capture_pc = 1'b1;
          hit_inc    = bp_hit;
        end
      end
      S_HALTED: begin
        if (Run) begin
          state_nxt     = S_CONT;
          step_mode_nxt = 1'b0;
        end else if (Step) begin
          state_nxt     = S_CONT;
          step_mode_nxt = 1'b1;
        end
      end
      S_CONT: begin
        if (step_mode) begin
          state_nxt = S_STEP;
        end else begin
          state_nxt = S_RUN;
          skip_nxt  = 1'b1;
        end
      end
      S_STEP: begin
        if (!Stall) begin
          state_nxt  = S_HALTED;
          capture_pc = 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Registered outputs, counters, breakpoint register and resume bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      Break     <= 1'b0;
      Continue  <= 1'b0;
      Halted    <= 1'b0;
      BreakPC   <= '0;
      instr_cnt <= '0;
      HitCount  <= '0;
      bp_reg    <= '0;
      skip      <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      Break     <= (state_nxt == S_HALTED);
      Halted    <= (state_nxt == S_HALTED);
      Continue  <= (state_nxt == S_CONT);
      skip      <= skip_nxt;
      step_mode <= step_mode_nxt;
      if (capture_pc) BreakPC <= PC;
      if (hit_inc && (HitCount != 8'hff)) HitCount <= HitCount + 8'd1;
      if (advance) instr_cnt <= instr_cnt + 32'd1;
      if (BpSet) bp_reg <= BpAddr;
    end
  end

endmodule
